// File: rtl/uart_tx.sv
// UART transmitter: 8N1/8N2 framing with a valid/ready byte handshake and registered outputs.
// Optional even-parity bit is built when macro UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_tx_serial,
  output logic       o_tx_busy,
  output logic       o_tx_done
);

  localparam int              CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic             stop_idx_q;
  logic [7:0]       shift_q;
  logic             serial_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
`ifdef UART_TX_PARITY_EN
  logic             parity_q;
`endif

  logic bit_end;
  assign bit_end = (cnt_q == CNT_MAX);

  // NOTE: all state lives in one always_ff with non-blocking assignments and an
  // asynchronous reset in the sensitivity list, so every output is a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      serial_q   <= 1'b1;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      cnt_q  <= bit_end ? '0 : cnt_q + CNT_W'(1);
      case (state_q)
        IDLE: begin
          cnt_q    <= '0;
          serial_q <= 1'b1;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
          if (i_tx_valid && ready_q) begin
            shift_q    <= i_tx_data;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            state_q    <= START;
            serial_q   <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= ^i_tx_data;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state_q   <= DATA;
            serial_q  <= shift_q[0];
            bit_idx_q <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q    <= PARITY;
              serial_q   <= parity_q;
`else
              state_q    <= STOP;
              serial_q   <= 1'b1;
              stop_idx_q <= 1'b0;
`endif
            end else begin
              // Shift right so the next LSB-first bit always sits at shift_q[1].
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              serial_q  <= shift_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state_q    <= STOP;
            serial_q   <= 1'b1;
            stop_idx_q <= 1'b0;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (stop_idx_q == STOP_LAST) begin
              state_q  <= IDLE;
              done_q   <= 1'b1;
              ready_q  <= 1'b1;
              busy_q   <= 1'b0;
              serial_q <= 1'b1;
            end else begin
              stop_idx_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          cnt_q      <= '0;
          bit_idx_q  <= '0;
          stop_idx_q <= 1'b0;
          serial_q   <= 1'b1;
          ready_q    <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx_ready  = ready_q;
  assign o_tx_serial = serial_q;
  assign o_tx_busy   = busy_q;
  assign o_tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: cycle-exact frame checks plus a line receiver feeding a byte scoreboard.
// Expects parity frames when UART_TX_PARITY_EN is defined.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] data1, data4;
  logic       valid1, valid4;
  logic       ready1, serial1, busy1, done1;
  logic       ready4, serial4, busy4, done4;

  uart_tx #(.CLKS_PER_BIT(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .i_tx_data(data1), .i_tx_valid(valid1),
    .o_tx_ready(ready1), .o_tx_serial(serial1), .o_tx_busy(busy1), .o_tx_done(done1)
  );

  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut4 (
    .clk(clk), .reset(reset), .i_tx_data(data4), .i_tx_valid(valid4),
    .o_tx_ready(ready4), .o_tx_serial(serial4), .o_tx_busy(busy4), .o_tx_done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for ready, then handshake one byte; returns at cycle 1 of the frame.
  task automatic accept(input logic [7:0] b, input bit hold);
    int n = 0;
    while (!ready1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", 64'(ready1), 64'(1));
    data1  = b;
    valid1 = 1'b1;
    exp_q.push_back(b);
    @(posedge clk); #1;
    if (!hold) valid1 = 1'b0;
  endtask

  // Sample one whole frame from cycle 1; returns sampling the done cycle.
  task automatic observe_frame(input logic [7:0] b, input string tag);
    logic [63:0] got = '0;
    logic [63:0] exp = '0;
    bit busy_ok = 1'b1, ready_low = 1'b1, done_seen = 1'b0;
    for (int i = 0; i < 8; i++) exp[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    exp[9]  = ^b;
    exp[10] = 1'b1;
`else
    exp[9]  = 1'b1;
`endif
    for (int i = 0; i < FRAME_BITS; i++) begin
      got[i] = serial1;
      if (busy1 !== 1'b1) busy_ok = 1'b0;
      if (ready1 !== 1'b0) ready_low = 1'b0;
      if (done1 !== 1'b0) done_seen = 1'b1;
      @(posedge clk); #1;
    end
    check({tag, "_serial"}, got, exp);
    check({tag, "_busy_high"}, 64'(busy_ok), 64'(1));
    check({tag, "_ready_low"}, 64'(ready_low), 64'(1));
    check({tag, "_no_early_done"}, 64'(done_seen), 64'(0));
    check({tag, "_done_rdy_busy_ser"}, 64'({done1, ready1, busy1, serial1}), 64'(4'b1101));
  endtask

  // Line receiver on dut1 (one clk per bit); frames that see reset are discarded.
  logic [7:0] rx_byte;
  logic       rx_par, rx_stop;
  logic [7:0] rx_exp;
  bit         rx_abort;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && serial1 === 1'b0) begin
        rx_abort = 1'b0;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          rx_abort |= reset;
          rx_byte[i] = serial1;
        end
`ifdef UART_TX_PARITY_EN
        @(negedge clk);
        rx_abort |= reset;
        rx_par = serial1;
`else
        rx_par = 1'b0;
`endif
        @(negedge clk);
        rx_abort |= reset;
        rx_stop = serial1;
        if (!rx_abort) begin
          if (exp_q.size() == 0) begin
            check("rx_unexpected_frame", 64'(1), 64'(0));
          end else begin
            rx_exp = exp_q.pop_front();
            check("rx_byte", 64'(rx_byte), 64'(rx_exp));
            check("rx_stop", 64'(rx_stop), 64'(1));
`ifdef UART_TX_PARITY_EN
            check("rx_parity", 64'(rx_par), 64'(^rx_exp));
`endif
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] got4, exp4;
    logic        bitval;
    bit          flag, flag2;
    int          n;

    reset = 1'b1; valid1 = 1'b0; data1 = '0; valid4 = 1'b0; data4 = '0;
    #12;
    check("rst_serial", 64'(serial1), 64'(1));
    check("rst_ready",  64'(ready1),  64'(0));
    check("rst_busy",   64'(busy1),   64'(0));
    check("rst_done",   64'(done1),   64'(0));
    check("rst_ready4", 64'(ready4),  64'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst",  64'(ready1), 64'(1));
    check("ready4_after_rst", 64'(ready4), 64'(1));

    accept(8'hA5, 1'b0); observe_frame(8'hA5, "a5");
    accept(8'h07, 1'b0); observe_frame(8'h07, "07");
    accept(8'h00, 1'b0); observe_frame(8'h00, "00");
    accept(8'hFF, 1'b0); observe_frame(8'hFF, "ff");
    accept(8'h5A, 1'b0); observe_frame(8'h5A, "5a");

    // Back-to-back: valid held, data changed mid-frame, second handshake in done cycle.
    accept(8'h3C, 1'b1);
    data1 = 8'hC3;
    observe_frame(8'h3C, "b2b_1");
    exp_q.push_back(8'hC3);
    @(posedge clk); #1;
    valid1 = 1'b0;
    observe_frame(8'hC3, "b2b_2");

    // Reset during DATA bit 3 of 0xFF (cycle 5).
    accept(8'hFF, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1;
    check("midrst_serial", 64'(serial1), 64'(1));
    check("midrst_busy",   64'(busy1),   64'(0));
    check("midrst_ready",  64'(ready1),  64'(0));
    check("midrst_done",   64'(done1),   64'(0));
    void'(exp_q.pop_back());
    flag = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done1 !== 1'b0) flag = 1'b1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    check("postrst_ready", 64'(ready1), 64'(1));
    check("postrst_done",  64'(done1 | flag), 64'(0));
    flag2 = 1'b0;
    repeat (5) begin
      if (serial1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) flag2 = 1'b1;
      @(posedge clk); #1;
    end
    check("postrst_no_resume", 64'(flag2), 64'(0));
    accept(8'h55, 1'b0); observe_frame(8'h55, "55");

    // CLKS_PER_BIT=4, byte 0x01.
    n = 0;
    while (!ready4 && n < 50) begin @(posedge clk); #1; n++; end
    check("ready4_wait", 64'(ready4), 64'(1));
    data4 = 8'h01; valid4 = 1'b1;
    @(posedge clk); #1;
    valid4 = 1'b0;
    got4 = '0; exp4 = '0; flag = 1'b0;
    for (int k = 0; k < FRAME_BITS; k++) begin
      if (k == 0)                   bitval = 1'b0;
      else if (k <= 8)              bitval = data4[k-1];
      else if (k == FRAME_BITS - 1) bitval = 1'b1;
      else                          bitval = ^data4;
      for (int j = 0; j < 4; j++) exp4[k*4+j] = bitval;
    end
    for (int i = 0; i < FRAME_BITS * 4; i++) begin
      got4[i] = serial4;
      if (done4 !== 1'b0 || busy4 !== 1'b1) flag = 1'b1;
      @(posedge clk); #1;
    end
    check("cpb4_serial", got4, exp4);
    check("cpb4_busy_nodone", 64'(flag), 64'(0));
    check("cpb4_done", 64'({done4, ready4, busy4}), 64'(3'b110));
    @(posedge clk); #1;
    check("cpb4_done_one_cycle", 64'(done4), 64'(0));

    repeat (20) @(posedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter: CLKS_PER_BIT, default 1, clk cycles per serial bit; legal values are 1 or greater.
REQ-002 SHALL provide parameter: STOP_BITS, default 1, number of stop bits; legal values are 1 or 2.
REQ-003 SHALL provide port: clk  input  1  rising-edge clock.
REQ-004 SHALL provide port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port: i_tx_data  input  8  byte to transmit.
REQ-006 SHALL provide port: i_tx_valid  input  1  byte offered.
REQ-007 SHALL provide port: o_tx_ready  output  1  block can accept a byte.
REQ-008 SHALL provide port: o_tx_serial  output  1  serial line; idles high.
REQ-009 SHALL provide port: o_tx_busy  output  1  frame in progress.
REQ-010 SHALL provide port: o_tx_done  output  1  one-cycle pulse when a frame completes.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY (present only under UART_TX_PARITY_EN) and STOP; all outputs SHALL be registered.
REQ-012 SHALL accept a byte only in IDLE when i_tx_valid and o_tx_ready are both high (handshake cycle N), latching i_tx_data into an internal shift register.
REQ-013 SHALL ignore i_tx_valid while o_tx_ready is low: no queueing, and i_tx_data changes SHALL NOT affect a frame in flight.
REQ-014 SHALL drive o_tx_serial low (START) from cycle N+1 for CLKS_PER_BIT cycles.
REQ-015 SHALL send DATA LSB first, each bit held CLKS_PER_BIT cycles, with a 3-bit index running 0..7 with no wrap past 7.
REQ-016 SHALL drive STOP high for STOP_BITS*CLKS_PER_BIT cycles, then return to IDLE.
REQ-017 SHALL produce a frame of (9+STOP_BITS)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT cycles when parity is enabled.
REQ-018 SHALL keep o_tx_ready low and o_tx_busy high from cycle N+1 until the IDLE entry cycle.
REQ-019 SHALL, in the IDLE entry cycle, pulse o_tx_done for one cycle with o_tx_ready high; a handshake in that cycle starts the next frame on the following cycle, giving exactly one idle-high cycle between back-to-back frames.
REQ-020 SHALL use a bit-period counter of max(1, clog2(CLKS_PER_BIT)) bits that counts 0..CLKS_PER_BIT-1 and reloads to 0 at each bit boundary; with CLKS_PER_BIT=1 every state lasts exactly one cycle.
REQ-021 SHALL hold o_tx_serial high in IDLE, and SHALL return any illegal state encoding to IDLE with the line high.

Reset
REQ-022 SHALL, while reset is high, immediately force: o_tx_serial=1, o_tx_ready=0, o_tx_busy=0, o_tx_done=0, state=IDLE, counters=0, shift register=0.
REQ-023 SHALL raise o_tx_ready in the first clk edge after reset deasserts.
REQ-024 SHALL, on reset asserted mid-frame, abort the frame with no done pulse, and SHALL NOT resume the aborted byte after release.

Configuration
REQ-025 SHALL, when macro UART_TX_PARITY_EN is defined, insert a PARITY bit between DATA and STOP equal to the XOR of the 8 data bits (even parity), held CLKS_PER_BIT cycles.
REQ-026 SHALL, when UART_TX_PARITY_EN is undefined, go from DATA directly to STOP, with no PARITY state or parity logic synthesized.

Verification
REQ-027 SHALL cover: CLKS_PER_BIT=1, byte 0xA5 handshaked at cycle 0 -> o_tx_serial 0,1,0,1,0,0,1,0,1,1 over cycles 1-10, done pulse at cycle 11.
REQ-028 SHALL cover: CLKS_PER_BIT=4, byte 0x01 -> start low for 4 cycles, bit0 high for 4, bits1-7 low for 28, stop high for 4, done at cycle 41.
REQ-029 SHALL cover: UART_TX_PARITY_EN, bytes 0xA5 and 0x07 -> parity bit 0 and 1 respectively, frame 11 bits, done at cycle 12.
REQ-030 SHALL cover: valid held high with 0x3C then 0xC3 -> two frames separated by exactly one idle-high cycle, and the second handshake in the done cycle.
REQ-031 SHALL cover: reset pulsed during DATA bit 3 of 0xFF -> line high asynchronously, no done pulse, ready at the first edge after release, and next byte 0x55 sent correctly.
REQ-032 SHALL cover: loopback of o_tx_serial into the team receiver, CLKS_PER_BIT=1, bytes 0x00, 0xFF and 0x5A -> receiver output equals each byte after its stop bit.
